pwm_dimmer_array: RTL and testbench

PWM_DIMMER_ARRAY -- requirements
Module: pwm_dimmer_array

---
 rtl/pwm_dimmer_array.sv | 109 ++++++++++
 tb/tb_pwm_dimmer_array.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dimmer_array.sv
// Multi-channel button-controlled PWM dimmer: synchronised, tick-debounced up/down
// buttons step a per-channel brightness level that drives a shared-counter PWM.
module pwm_dimmer_array #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned LEVELS   = 9,
    parameter int unsigned STEP     = 32,
    parameter int unsigned TICK_DIV = 120000,
    parameter int unsigned WRAP     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     btn_up,
    input  logic [CHANNELS-1:0]     btn_down,
    output logic [CHANNELS-1:0]     pwm_out,
    output logic [4*CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]     active
);

    localparam int unsigned NB    = 2 * CHANNELS;
    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned DW    = PWM_BITS + 4;
    localparam logic [3:0]    LVL_MAX  = 4'(LEVELS - 1);
    localparam logic [DW-1:0] DUTY_MAX = DW'({PWM_BITS{1'b1}});

    logic [NB-1:0] btn_c;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] samp_q, samp_d;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] chg_c, press_c;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_c;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                wrap_c;

    logic [CHANNELS-1:0][3:0]          lvl_q, lvl_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [CHANNELS-1:0][DW-1:0]       tgt_c;
    logic [CHANNELS-1:0]               act_q, act_d;
    logic [CHANNELS-1:0]               pwm_q, pwm_d;

    // Down buttons live in the upper half so channel i maps to bits i and CHANNELS+i.
    assign btn_c = {btn_down, btn_up};

    // Tick divider, debouncer and shared PWM counter.
    always_comb begin
        tick_c  = (div_q == DIV_W'(TICK_DIV - 1));
        div_d   = tick_c ? '0 : div_q + DIV_W'(1);
        chg_c   = ~(sync2_q ^ samp_q) & (sync2_q ^ deb_q);
        samp_d  = tick_c ? sync2_q : samp_q;
        deb_d   = tick_c ? (deb_q ^ chg_c) : deb_q;
        press_c = deb_d & ~deb_q;
        cnt_d   = cnt_q + PWM_BITS'(1);
        wrap_c  = &cnt_q;
    end

    // Per-channel level stepping, duty latch at period boundary and PWM compare.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lvl_d[i] = lvl_q[i];
            if (press_c[i] && !press_c[CHANNELS+i]) begin
                if (lvl_q[i] == LVL_MAX) lvl_d[i] = (WRAP != 0) ? 4'd0 : lvl_q[i];
                else                     lvl_d[i] = lvl_q[i] + 4'd1;
            end else if (!press_c[i] && press_c[CHANNELS+i]) begin
                if (lvl_q[i] == 4'd0) lvl_d[i] = (WRAP != 0) ? LVL_MAX : 4'd0;
                else                  lvl_d[i] = lvl_q[i] - 4'd1;
            end
            act_d[i]  = (lvl_d[i] != 4'd0);
            tgt_c[i]  = DW'(lvl_q[i]) * DW'(STEP);
            duty_d[i] = duty_q[i];
            if (wrap_c)
                duty_d[i] = (tgt_c[i] > DUTY_MAX) ? PWM_BITS'(DUTY_MAX) : PWM_BITS'(tgt_c[i]);
            pwm_d[i]  = (cnt_q < duty_q[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            lvl_q   <= '0;
            duty_q  <= '0;
            act_q   <= '0;
            pwm_q   <= '0;
        end else begin
            sync1_q <= btn_c;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            duty_q  <= duty_d;
            act_q   <= act_d;
            pwm_q   <= pwm_d;
        end
    end

    assign level   = lvl_q;
    assign active  = act_q;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_dimmer_array.sv
// Directed scoreboard bench for pwm_dimmer_array; a wrapping and a saturating
// instance share the same stimulus and are each checked against a level model.
module tb_pwm_dimmer_array;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  up    = 3'b000;
    logic [2:0]  dn    = 3'b000;
    logic [2:0]  pwm_w, act_w, pwm_s, act_s;
    logic [11:0] lvl_w, lvl_s;

    pwm_dimmer_array #(.CHANNELS(3), .PWM_BITS(8), .LEVELS(9), .STEP(32),
                       .TICK_DIV(4), .WRAP(1)) dut_w (
        .clock(clk), .reset(rst_n), .btn_up(up), .btn_down(dn),
        .pwm_out(pwm_w), .level(lvl_w), .active(act_w));

    pwm_dimmer_array #(.CHANNELS(3), .PWM_BITS(8), .LEVELS(9), .STEP(32),
                       .TICK_DIV(4), .WRAP(0)) dut_s (
        .clock(clk), .reset(rst_n), .btn_up(up), .btn_down(dn),
        .pwm_out(pwm_s), .level(lvl_s), .active(act_s));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t        sbq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] mw[3];
    logic [3:0] ms[3];

    function automatic logic [3:0] model_next(input logic [3:0] l, input logic u,
                                              input logic d, input bit wrap);
        if (u && !d) return (l == 4'd8) ? (wrap ? 4'd0 : 4'd8) : l + 4'd1;
        if (d && !u) return (l == 4'd0) ? (wrap ? 4'd8 : 4'd0) : l - 4'd1;
        return l;
    endfunction

    function automatic int duty_exp(input logic [3:0] l);
        int d;
        d = int'(l) * 32;
        return (d > 255) ? 255 : d;
    endfunction

    function automatic logic [31:0] lvl_exp_w();
        return 32'({mw[2], mw[1], mw[0]});
    endfunction
    function automatic logic [31:0] lvl_exp_s();
        return 32'({ms[2], ms[1], ms[0]});
    endfunction
    function automatic logic [31:0] act_exp_w();
        return 32'({mw[2] != 4'd0, mw[1] != 4'd0, mw[0] != 4'd0});
    endfunction
    function automatic logic [31:0] act_exp_s();
        return 32'({ms[2] != 4'd0, ms[1] != 4'd0, ms[0] != 4'd0});
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t s;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
            return;
        end
        s = sbq.pop_front();
        assert (obs === s.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", s.tag, obs, s.exp);
        end
    endtask

    task automatic push_state(input string tag);
        push({tag, "_lvl_w"}, lvl_exp_w());
        push({tag, "_act_w"}, act_exp_w());
        push({tag, "_lvl_s"}, lvl_exp_s());
        push({tag, "_act_s"}, act_exp_s());
    endtask

    task automatic check_state();
        check(32'(lvl_w));
        check(32'(act_w));
        check(32'(lvl_s));
        check(32'(act_s));
    endtask

    // Hold the buttons for three ticks, release for four, then compare levels.
    task automatic press(input logic [2:0] u, input logic [2:0] d, input string tag);
        @(negedge clk);
        up = u;
        dn = d;
        for (int i = 0; i < 3; i++) begin
            mw[i] = model_next(mw[i], u[i], d[i], 1'b1);
            ms[i] = model_next(ms[i], u[i], d[i], 1'b0);
        end
        push_state(tag);
        repeat (12) @(negedge clk);
        up = 3'b000;
        dn = 3'b000;
        repeat (16) @(negedge clk);
        check_state();
    endtask

    // Count high cycles over one full period once the new duty is applied.
    task automatic pwm_check(input int ch, input string tag);
        int nw, ns;
        push({tag, "_pwm_w"}, 32'(duty_exp(mw[ch])));
        push({tag, "_pwm_s"}, 32'(duty_exp(ms[ch])));
        nw = 0;
        ns = 0;
        repeat (260) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            nw += int'(pwm_w[ch]);
            ns += int'(pwm_s[ch]);
        end
        check(32'(nw));
        check(32'(ns));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mw[i] = 4'd0;
            ms[i] = 4'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        push_state("reset");
        push("reset_pwm_w", 32'd0);
        push("reset_pwm_s", 32'd0);
        check_state();
        check(32'(pwm_w));
        check(32'(pwm_s));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic increment and its PWM duty
        press(3'b001, 3'b000, "inc_first");
        pwm_check(0, "inc_first");

        // Up to the top of the range: wrap returns to 0, saturate holds at 8
        for (int n = 0; n < 8; n++) press(3'b001, 3'b000, "up_seq");
        pwm_check(0, "top_end");

        // Down at level 0
        press(3'b000, 3'b100, "down_at_zero");
        pwm_check(2, "down_at_zero");

        // Single-tick glitch must be rejected
        @(negedge clk);
        up = 3'b010;
        repeat (3) @(negedge clk);
        up = 3'b000;
        push_state("glitch");
        repeat (28) @(negedge clk);
        check_state();

        // Up and down together cancel
        press(3'b010, 3'b010, "up_down_same");

        // Simultaneous events on channels 0 and 2
        press(3'b101, 3'b000, "indep");

        // Reach levels (5,3,8) on the wrapping instance
        press(3'b011, 3'b100, "build_a");
        press(3'b011, 3'b000, "build_b");
        press(3'b011, 3'b000, "build_c");
        press(3'b001, 3'b000, "build_d");

        // Asynchronous reset mid-period
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mw[i] = 4'd0;
            ms[i] = 4'd0;
        end
        push_state("mid_reset");
        push("mid_reset_pwm_w", 32'd0);
        push("mid_reset_pwm_s", 32'd0);
        #1;
        check_state();
        check(32'(pwm_w));
        check(32'(pwm_s));

        // Button held through reset release gives exactly one event
        up = 3'b001;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        mw[0] = 4'd1;
        ms[0] = 4'd1;
        push_state("held_after_reset");
        repeat (40) @(negedge clk);
        check_state();
        repeat (20) @(negedge clk);
        up = 3'b000;
        push_state("held_single_event");
        repeat (16) @(negedge clk);
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
